shift_add_mult_ctrl: RTL

//  Sequential unsigned W x W multiplier controller. It sequences one shared
//  W-bit adder through a shift-and-add loop, one multiplier bit per clock.

---
 rtl/shift_add_mult_ctrl_pkg.sv | 17 +
 rtl/shift_add_mult_ctrl_if.sv | 34 +++
 rtl/shift_add_mult_ctrl_add_nbit.sv | 15 +
 rtl/shift_add_mult_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier.
// State encoding, default operand width and counter width function.
package mult_pkg;

  localparam int W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Requester-side bundle: start/a/b in, busy/done/p back.
// master = requester, slave = multiplier controller.
interface shift_add_mult_ctrl_if
  import mult_pkg::*;
#(
  parameter int W = W_DEF
);

  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  p
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output p
  );

endinterface

// File: rtl/shift_add_mult_ctrl_add_nbit.sv
// W-bit adder shared by every shift-add step.
// Carry-in is tied to zero; carry-out feeds the product MSB.
module add_nbit #(
  parameter int W = 6
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] s,
  output logic         cout
);

  // plain unsigned sum with carry-out
  assign {cout, s} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned W x W shift-and-add multiplier controller.
// EARLY_TERM_EN: stop as soon as the remaining multiplier bits are zero.
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int W = W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  shift_add_mult_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_w(W);

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   mcand_q;
  logic [W-1:0]   mcand_d;
  logic [2*W:0]   p_q;
  logic [2*W:0]   p_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [W-1:0]   addend;
  logic [W-1:0]   sum;
  logic           cout;
  logic [2*W:0]   acc;
  logic           last;

  assign addend = p_q[0] ? mcand_q : '0;

  add_nbit #(
    .W(W)
  ) u_add (
    .x   (p_q[2*W-1:W]),
    .y   (addend),
    .s   (sum),
    .cout(cout)
  );

  // adding zero when P[0]=0 leaves hi unchanged
  assign acc  = {cout, sum, p_q[W-1:0]};
  assign last = (cnt_q == CNT_W'(W - 1));

`ifdef EARLY_TERM_EN
  logic [W-1:0]   rem_mask;
  logic           rem_zero;
  logic [CNT_W:0] skip;

  assign rem_mask = {W{1'b1}} >> cnt_q;
  assign rem_zero = (p_q[W-1:0] & rem_mask) == '0;
  assign skip     = (CNT_W+1)'(W) - {1'b0, cnt_q};
`endif

  // state, multiplicand, product and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state and datapath update for each FSM state
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = bus.a;
          p_d     = {1'b0, {W{1'b0}}, bus.b};
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
`ifdef EARLY_TERM_EN
        if (rem_zero) begin
          p_d     = p_q >> skip;
          state_d = DONE;
        end else begin
          p_d   = acc >> 1;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) state_d = DONE;
        end
`else
        p_d   = acc >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) state_d = DONE;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.p    = p_q[2*W-1:0];

endmodule
